// File: rtl/mem_stream_reader.sv
// Strided word reader for a 1-cycle-latency memory port, re-presented as a valid/ready stream.
// Optional feature macro STREAM_READER_SUM_EN adds a running sum of delivered words on sum_o.
module mem_stream_reader #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int STRIDE     = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_i,
    input  logic [LEN_WIDTH-1:0]  count_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_re_o,
    input  logic [DATA_WIDTH-1:0] mem_q_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i
`ifdef STREAM_READER_SUM_EN
    ,
    output logic [DATA_WIDTH-1:0] sum_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  count_q, count_d;
    logic [LEN_WIDTH-1:0]  issued_q, issued_d;
    logic                  inflight_q, inflight_d;

    logic [DATA_WIDTH-1:0] ent0_q, ent0_d;
    logic [DATA_WIDTH-1:0] ent1_q, ent1_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            fifo_cnt_q, fifo_cnt_d;

    logic                  start_acc;
    logic                  push;
    logic                  pop;
    logic [2:0]            held;
    logic [2:0]            room;
    logic                  can_issue;
    logic                  last_issue;

    assign start_acc = (state_q == S_IDLE) && start_i;
    assign push      = inflight_q;
    assign pop       = out_valid_o & out_ready_i;

    // A word popped this cycle frees its slot for a read issued in the same cycle.
    assign held       = {1'b0, fifo_cnt_q} + {2'b00, inflight_q};
    assign room       = 3'd2 + {2'b00, pop};
    assign can_issue  = (state_q == S_RUN) && (issued_q < count_q) && (held < room);
    assign last_issue = can_issue && (issued_q == (count_q - LEN_WIDTH'(1)));

    assign mem_addr_o  = addr_q;
    assign out_valid_o = (fifo_cnt_q != 2'd0);
    assign out_data_o  = rd_ptr_q ? ent1_q : ent0_q;

    // FSM: state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = (count_i == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (last_issue) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Look ahead so DONE lands the cycle right after the final hand-off.
                if ((fifo_cnt_d == 2'd0) && !inflight_d) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy_o   = (state_q != S_IDLE);
        done_o   = (state_q == S_DONE);
        mem_re_o = can_issue;
    end

    always_comb begin
        addr_d     = addr_q;
        count_d    = count_q;
        issued_d   = issued_q;
        inflight_d = can_issue;
        ent0_d     = ent0_q;
        ent1_d     = ent1_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};

        if (start_acc) begin
            addr_d   = base_i;
            count_d  = count_i;
            issued_d = '0;
        end else if (can_issue) begin
            addr_d   = addr_q + ADDR_WIDTH'(STRIDE);
            issued_d = issued_q + LEN_WIDTH'(1);
        end

        if (push) begin
            if (wr_ptr_q) begin
                ent1_d = mem_q_i;
            end else begin
                ent0_d = mem_q_i;
            end
            wr_ptr_d = ~wr_ptr_q;
        end

        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q     <= '0;
            count_q    <= '0;
            issued_q   <= '0;
            inflight_q <= 1'b0;
            ent0_q     <= '0;
            ent1_q     <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_cnt_q <= 2'd0;
        end else begin
            addr_q     <= addr_d;
            count_q    <= count_d;
            issued_q   <= issued_d;
            inflight_q <= inflight_d;
            ent0_q     <= ent0_d;
            ent1_q     <= ent1_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

`ifdef STREAM_READER_SUM_EN
    logic [DATA_WIDTH-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (start_acc) begin
            sum_d = '0;
        end else if (pop) begin
            sum_d = sum_q + out_data_o;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;
`endif

endmodule

// File: tb/tb_mem_stream_reader.sv
// Randomised bench for mem_stream_reader: memory model plus a per-command expected word list.
module tb_mem_stream_reader;
    localparam int AW = 20;
    localparam int DW = 32;
    localparam int LW = 16;
    localparam int STRIDE = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base;
    logic [LW-1:0] count;
    logic          busy, done, mem_re, out_valid, out_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_q, out_data;
`ifdef STREAM_READER_SUM_EN
    logic [DW-1:0] sum;
`endif

    int checks = 0;
    int errors = 0;
    int mem_mode = 0;
    logic [AW-1:0] rd_log [$];

    always #5 clk = ~clk;

    mem_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .STRIDE(STRIDE)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .base_i      (base),
        .count_i     (count),
        .busy_o      (busy),
        .done_o      (done),
        .mem_addr_o  (mem_addr),
        .mem_re_o    (mem_re),
        .mem_q_i     (mem_q),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready)
`ifdef STREAM_READER_SUM_EN
        ,
        .sum_o       (sum)
`endif
    );

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        case (mem_mode)
            1:       return 32'd1;
            2:       return DW'(a);
            default: return (DW'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
        endcase
    endfunction

    always @(posedge clk) if (mem_re === 1'b1) mem_q <= mem_word(mem_addr);

    // rmode: 0 ready always high, 1 ready toggles, 2 ready random. glitch: cycle with a stray START.
    task automatic run_cmd(input logic [AW-1:0] b, input int n, input int rmode, input int glitch);
        logic [DW-1:0] exp_q [$];
        logic [DW-1:0] pdata;
        logic [DW-1:0] exp_sum;
        int reads, xfers, c, last_x, outst;
        bit pv_stall, seen_done;
        exp_sum = '0;
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(mem_word(AW'(32'(b) + k * STRIDE)));
            exp_sum = exp_sum + exp_q[k];
        end
        rd_log.delete();
        @(negedge clk);
        start = 1'b1; base = b; count = LW'(n); out_ready = (rmode != 1);
        @(negedge clk);
        start = 1'b0; base = AW'($urandom); count = LW'($urandom);
        c = 1; reads = 0; xfers = 0; last_x = 0; pv_stall = 0; seen_done = 0; pdata = '0;
        while (!seen_done && c < 2000) begin
            start = (c == glitch);
            out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? c[0] : 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL busy_active c=%0d got %b exp 1", c, busy); end
            if (mem_re === 1'b1) begin
                checks++;
                if (reads >= n || mem_addr !== AW'(32'(b) + reads * STRIDE)) begin
                    errors++; $display("FAIL rd_addr c=%0d k=%0d got %h exp %h", c, reads, mem_addr, AW'(32'(b) + reads * STRIDE));
                end
                if (rmode == 0) begin
                    checks++;
                    if (c != reads + 1) begin errors++; $display("FAIL rd_cycle k=%0d got %0d exp %0d", reads, c, reads + 1); end
                end
                rd_log.push_back(mem_addr);
                reads++;
            end
            outst = reads - xfers - ((out_valid === 1'b1 && out_ready) ? 1 : 0);
            checks++;
            if (outst > 2) begin errors++; $display("FAIL credit c=%0d held %0d exp <=2", c, outst); end
            if (pv_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== pdata) begin
                    errors++; $display("FAIL stall_hold c=%0d got %b/%h exp 1/%h", c, out_valid, out_data, pdata);
                end
            end
            if (out_valid === 1'b1 && xfers >= n) begin
                errors++; $display("FAIL extra_valid c=%0d got 1 exp 0", c);
            end
            if (out_valid === 1'b1 && out_ready && xfers < n) begin
                checks++;
                if (out_data !== exp_q[xfers]) begin
                    errors++; $display("FAIL data k=%0d got %h exp %h", xfers, out_data, exp_q[xfers]);
                end
                if (rmode == 0) begin
                    checks++;
                    if (c != xfers + 3) begin errors++; $display("FAIL xfer_cycle k=%0d got %0d exp %0d", xfers, c, xfers + 3); end
                end
                xfers++;
                last_x = c;
            end
            pv_stall = (out_valid === 1'b1) && !out_ready;
            pdata = out_data;
            if (done === 1'b1) begin
                seen_done = 1;
                checks++;
                if (xfers != n || reads != n) begin
                    errors++; $display("FAIL totals got x%0d r%0d exp %0d", xfers, reads, n);
                end
                checks++;
                if (c != ((n == 0) ? 1 : last_x + 1)) begin
                    errors++; $display("FAIL done_cycle got %0d exp %0d", c, (n == 0) ? 1 : last_x + 1);
                end
            end
            @(negedge clk);
            c++;
        end
        start = 1'b0; out_ready = 1'b0;
        checks++;
        if (!seen_done) begin errors++; $display("FAIL done_timeout got none exp pulse"); end
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || mem_re !== 1'b0) begin
            errors++; $display("FAIL post_idle got b%b d%b v%b r%b exp 0000", busy, done, out_valid, mem_re);
        end
`ifdef STREAM_READER_SUM_EN
        checks++;
        if (sum !== exp_sum) begin errors++; $display("FAIL sum_cmd got %h exp %h", sum, exp_sum); end
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || mem_re !== 1'b0 || out_valid !== 1'b0 ||
            mem_addr !== '0 || out_data !== '0) begin
            errors++;
            $display("FAIL %s got b%b d%b r%b v%b a%h q%h exp all 0", tag, busy, done, mem_re, out_valid, mem_addr, out_data);
        end
`ifdef STREAM_READER_SUM_EN
        checks++;
        if (sum !== '0) begin errors++; $display("FAIL %s_sum got %h exp 0", tag, sum); end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; base = '0; count = '0; out_ready = 1'b0;
        #1 check_reset_outputs("reset_async");
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_held");
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [AW-1:0] exp_a [4] = '{20'h00100, 20'h00104, 20'h00108, 20'h0010C};
        mem_mode = 2;
        run_cmd(20'h00100, 4, 0, 0);
        checks++;
        if (rd_log.size() != 4) begin errors++; $display("FAIL basic_nreads got %0d exp 4", rd_log.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_log[i] !== exp_a[i]) begin errors++; $display("FAIL basic_addr%0d got %h exp %h", i, rd_log[i], exp_a[i]); end
        end
        mem_mode = 0;
    endtask

    task automatic test_toggle_ready();
        run_cmd(AW'($urandom), 8, 1, 0);
    endtask

    task automatic test_zero_count();
        run_cmd(AW'($urandom), 0, 1, 0);
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_a [4] = '{20'hFFFF8, 20'hFFFFC, 20'h00000, 20'h00004};
        run_cmd(20'hFFFF8, 4, 0, 0);
        checks++;
        if (rd_log.size() != 4) begin errors++; $display("FAIL wrap_nreads got %0d exp 4", rd_log.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_log[i] !== exp_a[i]) begin errors++; $display("FAIL wrap_addr%0d got %h exp %h", i, rd_log[i], exp_a[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int xf;
        xf = 0;
        @(negedge clk);
        start = 1'b1; base = AW'($urandom); count = LW'(6); out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (out_valid === 1'b1 && out_ready) xf++;
            if (xf == 2) break;
            @(negedge clk);
        end
        checks++;
        if (xf != 2) begin errors++; $display("FAIL midreset_prefix got %0d exp 2", xf); end
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b0;
        run_cmd(20'h00000, 2, 0, 0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 14; t++) begin
            run_cmd(AW'($urandom), int'($urandom_range(0, 12)), int'($urandom_range(0, 2)),
                    ($urandom_range(0, 1) == 1) ? 2 : 0);
        end
    endtask

`ifdef STREAM_READER_SUM_EN
    task automatic test_sum();
        mem_mode = 1;
        run_cmd(AW'($urandom), 5, 0, 0);
        checks++;
        if (sum !== 32'd5) begin errors++; $display("FAIL sum_five got %h exp 5", sum); end
        repeat (3) @(negedge clk);
        #1 checks++;
        if (sum !== 32'd5) begin errors++; $display("FAIL sum_hold got %h exp 5", sum); end
        @(negedge clk);
        start = 1'b1; base = '0; count = LW'(3); out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1 checks++;
        if (sum !== '0) begin errors++; $display("FAIL sum_clear got %h exp 0", sum); end
        for (int i = 0; i < 50; i++) begin
            if (done === 1'b1) break;
            @(negedge clk);
            #1;
        end
        checks++;
        if (done !== 1'b1 || sum !== 32'd3) begin errors++; $display("FAIL sum_three got d%b %h exp d1 3", done, sum); end
        @(negedge clk);
        out_ready = 1'b0;
        mem_mode = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_toggle_ready();
        test_zero_count();
        test_wrap();
        test_reset_mid();
        test_random();
`ifdef STREAM_READER_SUM_EN
        test_sum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
